// File: rtl/pf_ram_pkg.sv
// Shared types and default sizes for the playfield memory controller.
package pf_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } pf_clr_state_t;

    localparam int PF_DW = 8;
    localparam int PF_AW = 10;

endpackage

// File: rtl/pf_ram_core.sv
// Playfield storage: one write port, NRD+1 registered read ports with
// write-to-read forwarding and a fill override on the read registers.
module pf_ram_core #(
    parameter int DW  = 8,
    parameter int AW  = 10,
    parameter int NRD = 2
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          fill,
    input  logic [DW-1:0] fill_val,
    input  logic [AW-1:0] raddr [NRD+1],
    input  logic          ren   [NRD+1],
    output logic [DW-1:0] rdata [NRD+1]
);

    localparam int DEPTH = 2**AW;

    // The array carries no reset; its contents become meaningful once the
    // clear sequencer has swept every address.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NRD + 1; i++) begin
                rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NRD + 1; i++) begin
                if (fill) begin
                    rdata[i] <= fill_val;
                end else if (ren[i]) begin
                    // A same-cycle write to the sampled address wins over the old word.
                    rdata[i] <= (we && (waddr == raddr[i])) ? wdata : mem[raddr[i]];
                end
            end
        end
    end

endmodule

// File: rtl/pf_ram_ctl.sv
// Playfield memory controller: CPU port, NRD video read ports and a clear
// sequencer that owns the array after reset or on clr_req.
module pf_ram_ctl
    import pf_ram_pkg::*;
#(
    parameter int          DW      = PF_DW,
    parameter int          AW      = PF_AW,
    parameter int          NRD     = 2,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          cs_l,
    input  logic          we_l,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic [AW-1:0] rd_addr [NRD],
    output logic [DW-1:0] rd_data [NRD],
    input  logic          clr_req,
    output logic          busy
);

    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    pf_clr_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] raddr [NRD+1];
    logic          ren   [NRD+1];
    logic [DW-1:0] rdata [NRD+1];

    logic cpu_wr;
    logic cpu_rd;

    assign cpu_wr = !cs_l && !we_l;
    assign cpu_rd = !cs_l &&  we_l;
    assign busy   = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sweep owns the write port; CPU writes during it are dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_din;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = CLR_VAL;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                mem_we = cpu_wr;
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Video ports occupy slots 0..NRD-1, the CPU port takes slot NRD.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            raddr[i]   = rd_addr[i];
            ren[i]     = 1'b1;
            rd_data[i] = rdata[i];
        end
        raddr[NRD] = cpu_addr;
        ren[NRD]   = cpu_rd;
        cpu_dout   = rdata[NRD];
    end

    pf_ram_core #(
        .DW  (DW),
        .AW  (AW),
        .NRD (NRD)
    ) u_core (
        .clk      (clk),
        .rst_l    (rst_l),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    (mem_wdata),
        .fill     (busy),
        .fill_val (CLR_VAL),
        .raddr    (raddr),
        .ren      (ren),
        .rdata    (rdata)
    );

endmodule

// File: tb/tb_pf_ram_ctl.sv
// Directed bench for pf_ram_ctl: a default 1Kx8 instance and a 64x16, 4-port
// instance filled with 0xBEEF.
module tb_pf_ram_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       rst_d_l;
    logic       cs_d_l, we_d_l, clr_d;
    logic [9:0] cpu_addr_d;
    logic [7:0] cpu_din_d, cpu_dout_d;
    logic [9:0] rd_addr_d [2];
    logic [7:0] rd_data_d [2];
    logic       busy_d;

    // parametrised instance
    logic        rst_p_l;
    logic        cs_p_l, we_p_l, clr_p;
    logic [5:0]  cpu_addr_p;
    logic [15:0] cpu_din_p, cpu_dout_p;
    logic [5:0]  rd_addr_p [4];
    logic [15:0] rd_data_p [4];
    logic        busy_p;

    int n_chk = 0;
    int n_bad = 0;
    int cyc;

    pf_ram_ctl u_def (
        .clk      (clk),
        .rst_l    (rst_d_l),
        .cs_l     (cs_d_l),
        .we_l     (we_d_l),
        .cpu_addr (cpu_addr_d),
        .cpu_din  (cpu_din_d),
        .cpu_dout (cpu_dout_d),
        .rd_addr  (rd_addr_d),
        .rd_data  (rd_data_d),
        .clr_req  (clr_d),
        .busy     (busy_d)
    );

    pf_ram_ctl #(
        .DW      (16),
        .AW      (6),
        .NRD     (4),
        .CLR_VAL (16'hBEEF)
    ) u_par (
        .clk      (clk),
        .rst_l    (rst_p_l),
        .cs_l     (cs_p_l),
        .we_l     (we_p_l),
        .cpu_addr (cpu_addr_p),
        .cpu_din  (cpu_din_p),
        .cpu_dout (cpu_dout_p),
        .rd_addr  (rd_addr_p),
        .rd_data  (rd_data_p),
        .clr_req  (clr_p),
        .busy     (busy_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts negedges (starting with the current one) at which busy is high.
    task automatic count_busy(input bit sel, output int n);
        n = 0;
        while ((sel ? busy_p : busy_d) && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_d_l = 1'b0; cs_d_l = 1'b1; we_d_l = 1'b1; clr_d = 1'b0;
        cpu_addr_d = '0; cpu_din_d = '0;
        rd_addr_d[0] = '0; rd_addr_d[1] = '0;
        rst_p_l = 1'b0; cs_p_l = 1'b1; we_p_l = 1'b1; clr_p = 1'b0;
        cpu_addr_p = '0; cpu_din_p = '0;
        for (int i = 0; i < 4; i++) rd_addr_p[i] = '0;

        step(); step();
        check("rst_busy", busy_d, 1);
        check("rst_cpu_dout", cpu_dout_d, 0);
        check("rst_rd0", rd_data_d[0], 0);
        check("rst_rd1", rd_data_d[1], 0);

        rst_d_l = 1'b1;
        count_busy(1'b0, cyc);
        check("clear_len_reset", cyc, 1024);

        // read of the last address after the power-up sweep
        rd_addr_d[0] = 10'h3FF; cs_d_l = 1'b0; we_d_l = 1'b1; cpu_addr_d = 10'h3FF;
        step();
        check("rd_3ff", rd_data_d[0], 8'h00);
        check("cpu_rd_3ff", cpu_dout_d, 8'h00);

        // CPU write then dual read of the same address
        cs_d_l = 1'b0; we_d_l = 1'b0; cpu_addr_d = 10'h123; cpu_din_d = 8'hA5;
        step();
        we_d_l = 1'b1; rd_addr_d[0] = 10'h123; rd_addr_d[1] = 10'h123;
        step();
        check("dual_rd0", rd_data_d[0], 8'hA5);
        check("dual_rd1", rd_data_d[1], 8'hA5);
        check("cpu_rd_123", cpu_dout_d, 8'hA5);

        // forwarding: write and read of 0x040 on the same edge
        we_d_l = 1'b0; cpu_addr_d = 10'h040; cpu_din_d = 8'h5A; rd_addr_d[1] = 10'h040;
        step();
        check("fwd_rd1", rd_data_d[1], 8'h5A);
        check("fwd_rd0_other", rd_data_d[0], 8'hA5);
        check("cpu_hold_on_write", cpu_dout_d, 8'hA5);

        // CPU port holds when deselected
        cs_d_l = 1'b1; we_d_l = 1'b1; cpu_addr_d = 10'h040;
        step();
        check("cpu_hold_idle", cpu_dout_d, 8'hA5);
        rd_addr_d[0] = 10'h040;
        step();
        check("rd_040", rd_data_d[0], 8'h5A);

        // seed 0x200, then clr_req together with a CPU write to 0x201
        cs_d_l = 1'b0; we_d_l = 1'b0; cpu_addr_d = 10'h200; cpu_din_d = 8'h77;
        step();
        cpu_addr_d = 10'h201; cpu_din_d = 8'h33; clr_d = 1'b1;
        step();
        clr_d = 1'b0;
        check("busy_after_req", busy_d, 1);
        cpu_addr_d = 10'h123; cpu_din_d = 8'hFF; rd_addr_d[0] = 10'h123;
        step();
        check("busy_override_rd0", rd_data_d[0], 8'h00);
        count_busy(1'b0, cyc);
        check("clear_len_req", cyc, 1023);
        cs_d_l = 1'b1; we_d_l = 1'b1;
        rd_addr_d[0] = 10'h123; rd_addr_d[1] = 10'h200;
        step();
        cs_d_l = 1'b0; cpu_addr_d = 10'h201;
        step();
        check("dropped_wr_123", rd_data_d[0], 8'h00);
        check("cleared_200", rd_data_d[1], 8'h00);
        check("cleared_201", cpu_dout_d, 8'h00);

        // normal writes resume after the clear
        we_d_l = 1'b0; cpu_addr_d = 10'h3FF; cpu_din_d = 8'h3C;
        step();
        we_d_l = 1'b1; rd_addr_d[1] = 10'h3FF;
        step();
        check("wr_after_clear", rd_data_d[1], 8'h3C);
        check("cpu_rd_3c", cpu_dout_d, 8'h3C);
        cs_d_l = 1'b1;

        // reset in the middle of the power-up sweep
        rst_d_l = 1'b0;
        step();
        rst_d_l = 1'b1;
        for (int i = 0; i < 500; i++) step();
        check("busy_at_500", busy_d, 1);
        rst_d_l = 1'b0;
        #1;
        check("mid_rst_busy", busy_d, 1);
        check("mid_rst_cpu_dout", cpu_dout_d, 0);
        step(); step();
        rst_d_l = 1'b1;
        count_busy(1'b0, cyc);
        check("clear_len_restart", cyc, 1024);

        // parametrised instance
        check("p_rst_busy", busy_p, 1);
        check("p_rst_rd3", rd_data_p[3], 0);
        rst_p_l = 1'b1;
        count_busy(1'b1, cyc);
        check("p_clear_len", cyc, 64);
        cs_p_l = 1'b0; we_p_l = 1'b1; cpu_addr_p = 6'd0;
        for (int i = 0; i < 4; i++) rd_addr_p[i] = 6'd0;
        step();
        for (int i = 0; i < 4; i++) check($sformatf("p_rd%0d_a0", i), rd_data_p[i], 16'hBEEF);
        check("p_cpu_a0", cpu_dout_p, 16'hBEEF);
        cpu_addr_p = 6'd63;
        for (int i = 0; i < 4; i++) rd_addr_p[i] = 6'd63;
        step();
        for (int i = 0; i < 4; i++) check($sformatf("p_rd%0d_a63", i), rd_data_p[i], 16'hBEEF);
        check("p_cpu_a63", cpu_dout_p, 16'hBEEF);

        // a write on the parametrised instance is visible to every port
        we_p_l = 1'b0; cpu_addr_p = 6'd17; cpu_din_p = 16'h1234;
        for (int i = 0; i < 4; i++) rd_addr_p[i] = 6'd17;
        step();
        check("p_fwd_rd2", rd_data_p[2], 16'h1234);
        we_p_l = 1'b1;
        step();
        check("p_rd0_17", rd_data_p[0], 16'h1234);
        check("p_cpu_17", cpu_dout_p, 16'h1234);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
